// File: rtl/brent_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : brent_pkg                                                      |
// | Desc    : op encoding and elaboration helpers for the Brent-Kung adder   |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package brent_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int prefix_levels(input int width);
    int n;
    n = 0;
    while ((1 << n) < width) n++;
    return n;
  endfunction

  // Spread the stages evenly over the step chain; the last step always registers.
  function automatic bit stage_cut(input int level, input int stages, input int total);
    return ((level + 1) * stages / total) != (level * stages / total);
  endfunction

  function automatic int stage_index(input int level, input int stages, input int total);
    return (level + 1) * stages / total - 1;
  endfunction

  // Levels 1..n are the up-sweep, levels n+1..2n-1 the down-sweep fill.
  function automatic bit bk_combine(input int level, input int bit_i, input int n);
    int span;
    if (level <= n) begin
      span = 1 << level;
      return ((bit_i + 1) % span) == 0;
    end
    span = 1 << (2 * n - level);
    return (((bit_i + 1) % span) == span / 2) && (bit_i + 1 > span);
  endfunction

  function automatic int bk_dist(input int level, input int n);
    if (level <= n) return 1 << (level - 1);
    return 1 << (2 * n - level - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/brent_gp_cell.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : brent_gp_cell                                                  |
// | Desc    : generate/propagate combine of a high and a low group           |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module brent_gp_cell (
  input  logic gh,
  input  logic ph,
  input  logic gl,
  input  logic pl,
  output logic g,
  output logic p
);
  assign g = gh | (ph & gl);
  assign p = ph & pl;
endmodule
`default_nettype wire

// File: rtl/brent_pipe_addsub.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : brent_pipe_addsub                                              |
// | Desc    : pipelined Brent-Kung add/subtract with valid/ready handshake   |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module brent_pipe_addsub
  import brent_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int PIPE_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int c_n     = prefix_levels(WIDTH);
  localparam int c_m     = 1 << c_n;
  localparam int c_total = 2 * c_n + 1;
  localparam int c_hs_lo = 2 * c_m;
  localparam int c_c     = 2 * c_m + WIDTH;
  localparam int c_am    = c_c + 1;
  localparam int c_bm    = c_c + 2;
  localparam int c_bw    = c_c + 3;

  // Stage handshake: a stage can load when anything at or after it is empty.
  logic [PIPE_STAGES-1:0] r_valid, w_en, w_vin, w_load;

  assign w_vin     = PIPE_STAGES'({r_valid, in_valid});
  assign in_ready  = ~rst & w_en[0];
  assign out_valid = r_valid[PIPE_STAGES-1];

  for (genvar j = 0; j < PIPE_STAGES; j++) begin : g_flow
    assign w_en[j]   = out_ready | ~(&r_valid[PIPE_STAGES-1:j]);
    assign w_load[j] = w_en[j] & w_vin[j];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else begin
      for (int j = 0; j < PIPE_STAGES; j++)
        if (w_en[j]) r_valid[j] <= w_vin[j];
    end
  end

  // Bus layout, LSB first: G[c_m], P[c_m], half-sum[WIDTH], c_eff, a msb, b_eff msb.
  logic [c_bw-1:0]  w_bus [2*c_n+1];
  logic [WIDTH-1:0] w_b_eff;
  logic             w_c_eff;
  logic [c_m-1:0]   w_a_pad, w_b_pad;

  assign w_b_eff = b ^ {WIDTH{sub == OP_SUB}};
  assign w_c_eff = cin ^ (sub == OP_SUB);

  always_comb begin
    w_a_pad = '0;
    w_b_pad = '0;
    w_a_pad[WIDTH-1:0] = a;
    w_b_pad[WIDTH-1:0] = w_b_eff;
  end

  assign w_bus[0] = {w_b_eff[WIDTH-1], a[WIDTH-1], w_c_eff, {WIDTH{1'b0}}, w_b_pad, w_a_pad};

  for (genvar k = 0; k < 2 * c_n; k++) begin : g_step
    logic [c_m-1:0]  w_g, w_p, w_go, w_po;
    logic [c_bw-1:0] w_comb;

    assign w_g = w_bus[k][c_m-1:0];
    assign w_p = w_bus[k][2*c_m-1:c_m];

    if (k == 0) begin : g_pre
      // Carry-in folds into bit 0 so G[i] becomes the carry out of bit i.
      always_comb begin
        w_go    = w_g & w_p;
        w_po    = w_g ^ w_p;
        w_go[0] = w_go[0] | (w_po[0] & w_bus[k][c_c]);
      end
      assign w_comb = {w_bus[k][c_bm:c_c], w_po[WIDTH-1:0], w_po, w_go};
    end else begin : g_tree
      for (genvar i = 0; i < c_m; i++) begin : g_bit
        if (bk_combine(k, i, c_n)) begin : g_cell
          localparam int c_d = bk_dist(k, c_n);
          brent_gp_cell u_cell (
            .gh(w_g[i]),
            .ph(w_p[i]),
            .gl(w_g[i-c_d]),
            .pl(w_p[i-c_d]),
            .g (w_go[i]),
            .p (w_po[i])
          );
        end else begin : g_pass
          assign w_go[i] = w_g[i];
          assign w_po[i] = w_p[i];
        end
      end
      assign w_comb = {w_bus[k][c_bw-1:c_hs_lo], w_po, w_go};
    end

    if (stage_cut(k, PIPE_STAGES, c_total)) begin : g_reg
      localparam int c_st = stage_index(k, PIPE_STAGES, c_total);
      logic [c_bw-1:0] r_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_q <= '0;
        else if (w_load[c_st]) r_q <= w_comb;
      end
      assign w_bus[k+1] = r_q;
    end else begin : g_wire
      assign w_bus[k+1] = w_comb;
    end
  end

  logic [c_bw-1:0]  w_last;
  logic [WIDTH-1:0] w_carry, w_sum;
  logic             w_cout, w_ovf;
  logic             w_unused;

  assign w_last   = w_bus[2*c_n];
  assign w_carry  = {w_last[WIDTH-2:0], w_last[c_c]};
  assign w_sum    = w_last[c_c-1:c_hs_lo] ^ w_carry;
  assign w_cout   = w_last[WIDTH-1];
  assign w_ovf    = (w_last[c_am] ~^ w_last[c_bm]) & (w_sum[WIDTH-1] ^ w_last[c_am]);
  assign w_unused = ^{w_bus[0][c_c-1:c_hs_lo], w_last[c_hs_lo-1:0]};

  logic [WIDTH-1:0] r_sum;
  logic             r_cout, r_ovf, r_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_load[PIPE_STAGES-1]) begin
      r_sum  <= w_sum;
      r_cout <= w_cout;
      r_ovf  <= w_ovf;
      r_zero <= ~|w_sum;
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;
  assign zero = r_zero;

endmodule
`default_nettype wire
